// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator processor control path:
// opcodes, sequencer states and ALU selects.
package acc_pkg;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_W = 3'd1,
        FETCH_B = 3'd2,
        DECODE  = 3'd3,
        OPER_W  = 3'd4,
        EXEC    = 3'd5,
        HALT    = 3'd6
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    function automatic logic [1:0] alu_for(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory latency counter: loaded with MEM_LAT on entry to a wait state,
// counts down, and flags the last wait cycle.
module mem_wait_cnt #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic clear,
    output logic done
);

    localparam int unsigned W = $clog2(MEM_LAT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (load)
            cnt <= W'(MEM_LAT);
        else if (clear)
            cnt <= '0;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/acc_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor;
// Moore-decoded strobes for PC, MAR, IR, ACC, memory write and ALU select.
module acc_ctrl_seq
    import acc_pkg::*;
#(
    parameter int unsigned OPW     = 3,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           acc_zero,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           mar_ld,
    output logic           mar_sel,
    output logic           ir_ld,
    output logic           acc_ld,
    output logic [1:0]     alu_op,
    output logic           mem_we,
    output logic           halted,
    output logic [2:0]     state_o
);

    state_t state, nxt;
    logic   wait_done, wait_load, wait_clear;

    always_comb begin
        nxt = state;
        case (state)
            FETCH_A: if (run) nxt = FETCH_W;
            FETCH_W: if (wait_done) nxt = FETCH_B;
            FETCH_B: nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_HLT:        nxt = HALT;
                    OP_JMP, OP_JZ: nxt = FETCH_A;
                    OP_STA:        nxt = EXEC;
                    default:       nxt = OPER_W;
                endcase
            end
            OPER_W:  if (wait_done) nxt = EXEC;
            EXEC:    nxt = FETCH_A;
            HALT:    nxt = HALT;
            default: nxt = FETCH_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            state <= FETCH_A;
        else
            state <= nxt;
    end

    // Load wins over clear so a direct hop into a wait state starts a fresh count.
    assign wait_clear = (nxt != state);
    assign wait_load  = wait_clear && (nxt == FETCH_W || nxt == OPER_W);

    mem_wait_cnt #(.MEM_LAT(MEM_LAT)) u_wait (
        .clk   (clk),
        .clr   (clr),
        .load  (wait_load),
        .clear (wait_clear),
        .done  (wait_done)
    );

    always_comb begin
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        mar_ld  = 1'b0;
        mar_sel = 1'b0;
        ir_ld   = 1'b0;
        acc_ld  = 1'b0;
        alu_op  = ALU_PASS;
        mem_we  = 1'b0;
        halted  = 1'b0;
        if (!clr) begin
            case (state)
                FETCH_A: mar_ld = run;
                FETCH_B: begin
                    ir_ld  = 1'b1;
                    pc_inc = 1'b1;
                end
                DECODE: begin
                    case (opcode)
                        OP_JMP: pc_ld = 1'b1;
                        OP_JZ:  pc_ld = acc_zero;
                        OP_HLT: ;
                        default: begin
                            mar_sel = 1'b1;
                            mar_ld  = 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    case (opcode)
                        OP_STA:                this_is_sta: mem_we = 1'b1;
                        OP_JMP, OP_JZ, OP_HLT: ;
                        default: begin
                            acc_ld = 1'b1;
                            alu_op = alu_for(opcode);
                        end
                    endcase
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_acc_ctrl_seq.sv
// Bench for acc_ctrl_seq at MEM_LAT=1 and MEM_LAT=3: directed cycle checks
// plus randomized traffic against a cycle-offset instruction model.
module tb_acc_ctrl_seq;
    import acc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic       run_s   [2];
    logic [2:0] op_s    [2];
    logic       az_s    [2];
    logic       pc_inc  [2];
    logic       pc_ld   [2];
    logic       mar_ld  [2];
    logic       mar_sel [2];
    logic       ir_ld   [2];
    logic       acc_ld  [2];
    logic [1:0] alu_op  [2];
    logic       mem_we  [2];
    logic       halted  [2];
    logic [2:0] st      [2];
    logic [9:0] vec     [2];

    acc_ctrl_seq #(.OPW(3), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .clr(clr), .run(run_s[0]), .opcode(op_s[0]), .acc_zero(az_s[0]),
        .pc_inc(pc_inc[0]), .pc_ld(pc_ld[0]), .mar_ld(mar_ld[0]), .mar_sel(mar_sel[0]),
        .ir_ld(ir_ld[0]), .acc_ld(acc_ld[0]), .alu_op(alu_op[0]), .mem_we(mem_we[0]),
        .halted(halted[0]), .state_o(st[0])
    );

    acc_ctrl_seq #(.OPW(3), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .clr(clr), .run(run_s[1]), .opcode(op_s[1]), .acc_zero(az_s[1]),
        .pc_inc(pc_inc[1]), .pc_ld(pc_ld[1]), .mar_ld(mar_ld[1]), .mar_sel(mar_sel[1]),
        .ir_ld(ir_ld[1]), .acc_ld(acc_ld[1]), .alu_op(alu_op[1]), .mem_we(mem_we[1]),
        .halted(halted[1]), .state_o(st[1])
    );

    // Bit order: pc_inc pc_ld mar_ld mar_sel ir_ld acc_ld alu_op[1:0] mem_we halted
    assign vec[0] = {pc_inc[0], pc_ld[0], mar_ld[0], mar_sel[0], ir_ld[0], acc_ld[0],
                     alu_op[0], mem_we[0], halted[0]};
    assign vec[1] = {pc_inc[1], pc_ld[1], mar_ld[1], mar_sel[1], ir_ld[1], acc_ld[1],
                     alu_op[1], mem_we[1], halted[1]};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per instance, cycles since the fetch strobe (k=1 is first wait cycle).
    bit m_busy  [2];
    bit m_hl    [2];
    bit m_known [2];
    int m_k     [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [9:0] exp_out(input int lat, input bit bsy, input int kk,
                                           input bit hl, input logic c, input logic r,
                                           input logic [2:0] op, input logic az);
        logic pci, pcl, marl, mars, irl, accl, we, h;
        logic [1:0] alu;
        {pci, pcl, marl, mars, irl, accl, alu, we, h} = '0;
        if (c) begin
        end else if (hl) begin
            h = 1'b1;
        end else if (!bsy) begin
            marl = r;
        end else if (kk == lat + 1) begin
            irl = 1'b1;
            pci = 1'b1;
        end else if (kk == lat + 2) begin
            if (op == 3'd5)      pcl = 1'b1;
            else if (op == 3'd6) pcl = az;
            else if (op != 3'd7) begin
                mars = 1'b1;
                marl = 1'b1;
            end
        end else if (op == 3'd1) begin
            if (kk == lat + 3) we = 1'b1;
        end else if (op <= 3'd4 && kk == 2 * lat + 3) begin
            accl = 1'b1;
            alu  = (op == 3'd2) ? 2'd1 : (op == 3'd3) ? 2'd2 : (op == 3'd4) ? 2'd3 : 2'd0;
        end
        return {pci, pcl, marl, mars, irl, accl, alu, we, h};
    endfunction

    task automatic model_step(input int d);
        int end_k;
        if (clr) begin
            m_known[d] = 1'b1;
            m_busy[d]  = 1'b0;
            m_hl[d]    = 1'b0;
        end else if (!m_known[d] || m_hl[d]) begin
        end else if (!m_busy[d]) begin
            if (run_s[d]) begin
                m_busy[d] = 1'b1;
                m_k[d]    = 1;
            end
        end else begin
            end_k = (op_s[d] >= 3'd5) ? lat_of(d) + 2 :
                    (op_s[d] == 3'd1) ? lat_of(d) + 3 : 2 * lat_of(d) + 3;
            if (m_k[d] == end_k) begin
                m_busy[d] = 1'b0;
                m_hl[d]   = (op_s[d] == 3'd7);
            end else begin
                m_k[d] = m_k[d] + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (clr || m_known[d]) begin
                check($sformatf("model_out_lat%0d", lat_of(d)), vec[d],
                      exp_out(lat_of(d), m_busy[d], m_k[d], m_hl[d], clr, run_s[d], op_s[d], az_s[d]));
                if (!clr && (m_hl[d] || !m_busy[d]))
                    check($sformatf("model_state_lat%0d", lat_of(d)), {7'b0, st[d]},
                          m_hl[d] ? 10'd6 : 10'd0);
            end
            model_step(d);
        end
    end

    logic [9:0] rec  [1:16];
    logic [2:0] recs [1:16];

    task automatic run_instr(input int d, input logic [2:0] op, input logic az,
                             input int n, input int drop_at);
        op_s[d]  = op;
        az_s[d]  = az;
        run_s[d] = 1'b1;
        for (int c = 1; c <= n; c++) begin
            if (c == drop_at) run_s[d] = 1'b0;
            @(negedge clk);
            rec[c]  = vec[d];
            recs[c] = st[d];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [9:0] acc_seen;
        int hcnt;
        clr = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_s[d] = 1'b0;
            op_s[d]  = 3'd0;
            az_s[d]  = 1'b0;
        end
        run_s[0] = 1'b1;
        @(negedge clk);
        check("clr_cycle1", vec[0], 10'b0);
        @(negedge clk);
        check("clr_cycle2", vec[0], 10'b0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        run_instr(0, OP_ADD, 1'b0, 6, 0);
        check("release_fetch", rec[1], 10'b0010000000);
        check("release_state", {7'b0, recs[1]}, 10'd0);
        check("add_ir_ld", rec[3], 10'b1000100000);
        check("add_mar_ld", rec[4], 10'b0011000000);
        check("add_acc_ld", rec[6], 10'b0000010100);

        run_instr(0, OP_STA, 1'b0, 5, 0);
        check("sta_mem_we", rec[5], 10'b0000000010);
        acc_seen = '0;
        for (int c = 1; c <= 5; c++) acc_seen = acc_seen | (rec[c] & 10'b0000010000);
        check("sta_no_acc_ld", acc_seen, 10'b0);

        run_instr(0, OP_JZ, 1'b0, 4, 0);
        check("sta_back_fetch", {7'b0, recs[1]}, 10'd0);
        check("jz_not_taken", rec[4], 10'b0);
        run_instr(0, OP_JZ, 1'b1, 4, 0);
        check("jz_taken", rec[4], 10'b0100000000);
        run_instr(0, OP_JMP, 1'b0, 4, 0);
        check("jmp_pc_ld", rec[4], 10'b0100000000);

        run_instr(0, OP_HLT, 1'b0, 5, 0);
        check("hlt_decode", rec[4], 10'b0);
        check("hlt_halted", rec[5], 10'b0000000001);
        check("hlt_state", {7'b0, recs[5]}, 10'd6);
        for (int c = 0; c < 20; c++) begin
            run_s[0] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_hold", vec[0], 10'b0000000001);
            @(posedge clk);
            #1;
        end
        clr = 1'b1;
        @(negedge clk);
        check("halt_clr", vec[0], 10'b0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        run_s[0] = 1'b0;
        @(negedge clk);
        check("halt_released", vec[0], 10'b0);
        check("halt_released_state", {7'b0, st[0]}, 10'd0);
        @(posedge clk);
        #1;

        run_instr(1, OP_LDA, 1'b0, 12, 3);
        check("lat3_ir_ld", rec[5], 10'b1000100000);
        check("lat3_mar_ld", rec[6], 10'b0011000000);
        check("lat3_acc_ld", rec[10], 10'b0000010000);
        check("lat3_stall1", rec[11], 10'b0);
        check("lat3_stall_state", {7'b0, recs[11]}, 10'd0);
        check("lat3_stall2", rec[12], 10'b0);
        run_s[1] = 1'b1;
        @(negedge clk);
        check("lat3_resume", vec[1], 10'b0010000000);

        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            hcnt = (m_hl[0] || m_hl[1]) ? hcnt + 1 : 0;
            clr  = ($urandom_range(0, 59) == 0) || (hcnt > 25);
            for (int d = 0; d < 2; d++) begin
                az_s[d]  = 1'($urandom_range(0, 1));
                run_s[d] = ($urandom_range(0, 3) != 0);
                if (!m_busy[d] && !m_hl[d])
                    op_s[d] = ($urandom_range(0, 11) == 0) ? OP_HLT : 3'($urandom_range(0, 6));
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
